// File: rtl/lsu_stage.sv
// ============================================================================
// Module      : lsu_stage
// Description : Load/store pipeline stage. It captures one instruction, issues
//               at most one memory request and hands the result to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    // upstream (ex_ls)
    input  logic            m_valid_i,
    output logic            M_ready_o,
    input  logic            m_wenReg_i,
    input  logic [4:0]      m_rd_i,
    input  logic [XLEN-1:0] m_res_i,
    input  logic [XLEN-1:0] m_src1_i,
    input  logic            m_wenMem_i,
    input  logic            m_renMem_i,
    input  logic [1:0]      m_mask_i,
    input  logic            m_is_load_signed_i,
    input  logic [XLEN-1:0] m_npc_i,
    // memory request
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic            mem_req_wen_o,
    output logic [XLEN-1:0] mem_req_addr_o,
    output logic [XLEN-1:0] mem_req_wdata_o,
    output logic [3:0]      mem_req_wmask_o,
    // memory response
    input  logic            mem_rsp_valid_i,
    output logic            mem_rsp_ready_o,
    input  logic [XLEN-1:0] mem_rsp_rdata_i,
    // writeback
    output logic            w_valid_o,
    input  logic            w_ready_i,
    output logic            w_wenReg_o,
    output logic [4:0]      w_rd_o,
    output logic [XLEN-1:0] w_data_o,
    output logic [XLEN-1:0] w_npc_o,
    output logic            misalign_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic            wen_reg_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] res_q;
    logic [XLEN-1:0] src1_q;
    logic            wen_mem_q;
    logic            ren_mem_q;
    logic [1:0]      mask_q;
    logic            signed_q;
    logic [XLEN-1:0] npc_q;
    logic [XLEN-1:0] data_q;
    logic            misalign_q;

    logic            accept;
    logic            is_mem_in;
    logic            misaligned_in;
    logic [XLEN-1:0] rdata_shifted;
    logic [XLEN-1:0] load_data;
    logic [3:0]      base_mask;

    assign accept    = (state == S_IDLE) && m_valid_i;
    assign is_mem_in = m_wenMem_i | m_renMem_i;

    always_comb begin
        misaligned_in = 1'b0;
        case (m_mask_i)
            2'b00:   misaligned_in = 1'b0;
            2'b01:   misaligned_in = m_res_i[0];
            default: misaligned_in = |m_res_i[1:0];
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= S_IDLE;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            misalign_q <= accept && is_mem_in && misaligned_in;
        end
    end

    always_comb begin
        state_nxt       = state;
        M_ready_o       = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_rsp_ready_o = 1'b0;
        w_valid_o       = 1'b0;
        case (state)
            S_IDLE: begin
                M_ready_o = 1'b1;
                if (m_valid_i)
                    state_nxt = (is_mem_in && !misaligned_in) ? S_REQ : S_OUT;
            end
            S_REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) state_nxt = S_RSP;
            end
            S_RSP: begin
                mem_rsp_ready_o = 1'b1;
                if (mem_rsp_valid_i) state_nxt = S_OUT;
            end
            S_OUT: begin
                w_valid_o = 1'b1;
                if (w_ready_i) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Payload registers carry no reset; they are only observed behind a valid.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            wen_reg_q <= m_wenReg_i;
            rd_q      <= m_rd_i;
            res_q     <= m_res_i;
            src1_q    <= m_src1_i;
            wen_mem_q <= m_wenMem_i;
            ren_mem_q <= m_renMem_i;
            mask_q    <= m_mask_i;
            signed_q  <= m_is_load_signed_i;
            npc_q     <= m_npc_i;
            data_q    <= is_mem_in ? '0 : m_res_i;
        end else if (state == S_RSP && mem_rsp_valid_i) begin
            data_q    <= ren_mem_q ? load_data : '0;
        end
    end

    always_comb begin
        rdata_shifted = mem_rsp_rdata_i >> {res_q[1:0], 3'b000};
        case (mask_q)
            2'b00:   load_data = {{(XLEN-8){signed_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
            2'b01:   load_data = {{(XLEN-16){signed_q & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_data = rdata_shifted;
        endcase
    end

    always_comb begin
        mem_req_wdata_o = src1_q;
        base_mask       = 4'b1111;
        case (mask_q)
            2'b00: begin
                mem_req_wdata_o = {4{src1_q[7:0]}};
                base_mask       = 4'b0001;
            end
            2'b01: begin
                mem_req_wdata_o = {2{src1_q[15:0]}};
                base_mask       = 4'b0011;
            end
            default: begin
                mem_req_wdata_o = src1_q;
                base_mask       = 4'b1111;
            end
        endcase
    end

    // Both enables high is treated as a load, so the store side is suppressed.
    assign mem_req_wen_o   = wen_mem_q & ~ren_mem_q;
    assign mem_req_wmask_o = mem_req_wen_o ? (base_mask << res_q[1:0]) : 4'b0000;
    assign mem_req_addr_o  = {res_q[XLEN-1:2], 2'b00};

    assign w_wenReg_o = wen_reg_q;
    assign w_rd_o     = rd_q;
    assign w_data_o   = data_q;
    assign w_npc_o    = npc_q;
    assign misalign_o = misalign_q;

endmodule

`default_nettype wire

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 Parameter XLEN, default 32, meaning data/address width; only 32 is supported.
REQ-002 clk_i  in  1  clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-low.
REQ-004 m_valid_i  in  1  upstream (ex_ls register) holds a valid instruction.
REQ-005 M_ready_o  out  1  stage can accept an instruction this cycle.
REQ-006 m_wenReg_i / m_rd_i[4:0]  in  register write enable / destination.
REQ-007 m_res_i  in  XLEN  ALU result; effective address for memory ops.
REQ-008 m_src1_i  in  XLEN  store data.
REQ-009 m_wenMem_i / m_renMem_i  in  1  store / load; both high is illegal, treated as load.
REQ-010 m_mask_i  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-011 m_is_load_signed_i  in  1  sign-extend load result.
REQ-012 m_npc_i  in  XLEN  next PC, passed through.
REQ-013 mem_req_valid_o / mem_req_ready_i  out/in  1  memory request handshake.
REQ-014 mem_req_wen_o  out  1; mem_req_addr_o  out  XLEN (addr[1:0] forced 00); mem_req_wdata_o  out  XLEN; mem_req_wmask_o  out  4  byte enables.
REQ-015 mem_rsp_valid_i / mem_rsp_ready_o  in/out  1  response handshake; mem_rsp_rdata_i  in  XLEN.
REQ-016 w_valid_o / w_ready_i  out/in  1  handshake to writeback register.
REQ-017 w_wenReg_o, w_rd_o[4:0], w_data_o XLEN, w_npc_o XLEN  out  result to writeback.
REQ-018 misalign_o  out  1  one-cycle pulse on misaligned access.

Function
REQ-019 FSM states IDLE, REQ, RSP, OUT; M_ready_o = (state==IDLE).
REQ-020 Accept on m_valid_i & M_ready_o: capture all inputs into internal registers; later input changes are ignored.
REQ-021 Accept, non-memory op: -> OUT, w_data_o = captured m_res_i.
REQ-022 Accept, memory op, misaligned (half with addr[0]=1, word with addr[1:0]!=0): -> OUT, no bus request, w_data_o = 0, misalign_o pulses the cycle after accept.
REQ-023 Accept, aligned memory op: -> REQ.
REQ-024 REQ: mem_req_valid_o=1; addr/wen/wdata/wmask stable until mem_req_ready_i; on handshake -> RSP.
REQ-025 Store wdata: byte replicated x4, half replicated x2, word as is; wmask = 0001/0011/1111 shifted left by addr[1:0]; loads drive wmask 0000.
REQ-026 RSP: mem_rsp_ready_o=1; on mem_rsp_valid_i -> OUT; loads capture rdata >> (8*addr[1:0]) truncated to size and sign/zero extended per m_is_load_signed_i; store result data = 0.
REQ-027 OUT: w_valid_o=1, outputs stable; on w_ready_i -> IDLE.
REQ-028 Latency accept-to-w_valid_o: 1 cycle non-memory/misaligned; 3 cycles for zero-wait memory; +1 per cycle of req or rsp stall.
REQ-029 Throughput at most one instruction per 2 cycles (no accept in OUT even when w_ready_i high).
REQ-030 mem_rsp_ready_o low outside RSP; responses outside RSP are ignored.
REQ-031 mem_req_valid_o never asserts outside REQ.

Reset
REQ-032 rst_i low at a clock edge: state -> IDLE; w_valid_o, mem_req_valid_o, mem_rsp_ready_o, misalign_o = 0; M_ready_o = 1 the following cycle.
REQ-033 Reset in REQ/RSP/OUT abandons the instruction; no writeback occurs; data registers need no reset.

Verification
REQ-034 ALU op res=0x1234, rd=5, wenReg=1, w_ready_i=1 -> w_valid_o 1 cycle after accept, w_data_o=0x1234, w_rd_o=5, no mem request.
REQ-035 Load byte signed addr=0x1003, rdata=0x80FF_0000, zero-wait -> mem_req_addr_o=0x1000, w_data_o=0xFFFF_FF80 at 3 cycles after accept.
REQ-036 Store half addr=0x2002, src1=0x0000_ABCD -> wdata=0xABCD_ABCD, wmask=1100, wen=1; w_valid_o after response with wenReg passed through.
REQ-037 Load word addr=0x3002 -> misalign_o pulse, no mem_req_valid_o, w_data_o=0.
REQ-038 Stall mem_req_ready_i 3 cycles and w_ready_i 2 cycles -> request fields stable throughout, M_ready_o low until OUT handshake, exactly one writeback.
REQ-039 Reset asserted while in RSP -> IDLE next cycle, late mem_rsp_valid_i ignored, no w_valid_o.
